if_queue: RTL and testbench

Instruction fetch queue sitting between the fetch stage (`o_pc`/`o_instr_req` producer) and the decode stage. It accepts one fetch request per cycle and issues it to instruction memory (valid/ready request, in-order variable-latency response). It buffers returned instructions with their PCs and presents them to decode over a valid/ready handshake. It back-pressures fetch via `o_stall` and discards wrong-path work on branch flush, including responses still in flight.

---
 rtl/if_queue_if.sv | 36 +++
 rtl/if_queue.sv | 89 ++++++++
 tb/tb_if_queue.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/if_queue_if.sv
// Fetch-queue signal bundle: fetch request/stall, memory request/response and
// decode handshake, grouped so the queue and its neighbours share one port.
`ifndef ADDR_W
`define ADDR_W 32
`endif

interface if_queue_if #(
  parameter int ADDR_W = `ADDR_W,
  parameter int DATA_W = 32
);
  logic              i_flush;
  logic [ADDR_W-1:0] i_pc;
  logic              i_instr_req;
  logic              o_stall;
  logic              o_mem_req;
  logic [ADDR_W-1:0] o_mem_addr;
  logic              i_mem_ready;
  logic              i_mem_rvalid;
  logic [DATA_W-1:0] i_mem_rdata;
  logic              o_valid;
  logic [ADDR_W-1:0] o_pc;
  logic [DATA_W-1:0] o_instr;
  logic              i_de_ready;

  modport slave (
    input  i_flush, i_pc, i_instr_req, i_mem_ready, i_mem_rvalid, i_mem_rdata,
           i_de_ready,
    output o_stall, o_mem_req, o_mem_addr, o_valid, o_pc, o_instr
  );

  modport master (
    output i_flush, i_pc, i_instr_req, i_mem_ready, i_mem_rvalid, i_mem_rdata,
           i_de_ready,
    input  o_stall, o_mem_req, o_mem_addr, o_valid, o_pc, o_instr
  );
endinterface

// File: rtl/if_queue.sv
// Instruction fetch queue: allocates fetch PCs, issues them to memory in order,
// buffers responses for decode and drops wrong-path responses after a flush.
`ifndef ADDR_W
`define ADDR_W 32
`endif

module if_queue #(
  parameter int ADDR_W = `ADDR_W,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input logic       clk,
  input logic       clr,
  if_queue_if.slave q
);
  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  logic [ADDR_W-1:0] pc_mem    [DEPTH];
  logic [DATA_W-1:0] instr_mem [DEPTH];

  // Slot state is implied by pointer order: [head,rsp) DONE, [rsp,iss) ISSUED,
  // [iss,tail) WAIT, everything else FREE.
  logic [PW-1:0] tail, iss, rsp, head;
  logic [PW-1:0] drop_cnt;

  logic [PW-1:0] used;
  logic [PW-1:0] n_issued;
  logic [PW:0]   stall_sum;
  logic          wait_vld;
  logic          done_vld;
  logic          alloc;
  logic          accept;
  logic          rsp_take;
  logic          rsp_drop;
  logic          retire;

  always_comb begin
    used      = tail - head;
    n_issued  = iss - rsp;
    wait_vld  = (iss != tail);
    done_vld  = (rsp != head);
    stall_sum = {1'b0, used} + {1'b0, drop_cnt} + {{PW{1'b0}}, q.i_instr_req};

    alloc    = q.i_instr_req & ~q.i_flush;
    accept   = wait_vld & q.i_mem_ready;
    rsp_drop = q.i_mem_rvalid & (drop_cnt != '0);
    rsp_take = q.i_mem_rvalid & (drop_cnt == '0);
    retire   = done_vld & ~q.i_flush & q.i_de_ready;
  end

  assign q.o_stall    = (stall_sum >= (PW+1)'(DEPTH));
  assign q.o_mem_req  = wait_vld;
  assign q.o_mem_addr = pc_mem[iss[IW-1:0]];
  assign q.o_valid    = done_vld & ~q.i_flush;
  assign q.o_pc       = pc_mem[head[IW-1:0]];
  assign q.o_instr    = instr_mem[head[IW-1:0]];

  // Slot payload: no reset, validity is carried entirely by the pointers.
  always_ff @(posedge clk) begin
    if (alloc)
      pc_mem[tail[IW-1:0]] <= q.i_pc;
    if (rsp_take & ~q.i_flush)
      instr_mem[rsp[IW-1:0]] <= q.i_mem_rdata;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      tail     <= '0;
      iss      <= '0;
      rsp      <= '0;
      head     <= '0;
      drop_cnt <= '0;
    end else if (q.i_flush) begin
      // Every transaction still outstanding after this edge becomes a drop,
      // including one accepted now; a response arriving now retires one.
      iss      <= tail;
      rsp      <= tail;
      head     <= tail;
      drop_cnt <= drop_cnt + n_issued + PW'(accept) - PW'(q.i_mem_rvalid);
    end else begin
      tail     <= tail + PW'(alloc);
      iss      <= iss + PW'(accept);
      rsp      <= rsp + PW'(rsp_take);
      head     <= head + PW'(retire);
      drop_cnt <= drop_cnt - PW'(rsp_drop);
    end
  end
endmodule

// File: tb/tb_if_queue.sv
// Randomized scoreboard bench for if_queue with an in-order variable-latency
// memory model and a queue-level reference of fetched entries.
module tb_if_queue;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  if_queue_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  if_queue #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .clr(clr),
    .q  (bus)
  );

  typedef struct {
    logic [AW-1:0] pc;
    bit            issued;
    bit            done;
  } ent_t;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } mt_t;

  ent_t sb[$];
  mt_t  mq[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_due = 0;
  int alloc_cnt = 0;
  int retired_cnt = 0;
  bit chk_en = 0;

  bit            last_stall = 0;
  bit            exp_mreq = 0;
  logic [AW-1:0] exp_addr = '0;
  logic [AW-1:0] next_pc = '0;

  int p_req, p_flush, p_de, p_mrdy, lat_max, p_clr;

  function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic int live_issued();
    int n = 0;
    foreach (sb[i]) if (sb[i].issued && !sb[i].done) n++;
    return n;
  endfunction

  function automatic int drop_model();
    return mq.size() - live_issued();
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // Monitor: compares DUT outputs against the reference each cycle and pops
  // the scoreboard on every decode handshake.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      begin
        int  e_drop;
        bit  e_stall, e_mreq, e_valid;
        logic [AW-1:0] e_addr;
        e_drop  = drop_model();
        e_stall = (sb.size() + e_drop + int'(bus.i_instr_req)) >= DEPTH;
        e_mreq  = 1'b0;
        e_addr  = '0;
        foreach (sb[i]) begin
          if (!e_mreq && !sb[i].issued) begin
            e_mreq = 1'b1;
            e_addr = sb[i].pc;
          end
        end
        e_valid = (sb.size() > 0) && sb[0].done && !bus.i_flush;
        if (chk_en) begin
          check("stall", 32'(bus.o_stall), 32'(e_stall));
          check("mem_req", 32'(bus.o_mem_req), 32'(e_mreq));
          if (e_mreq) check("mem_addr", bus.o_mem_addr, e_addr);
          check("valid", 32'(bus.o_valid), 32'(e_valid));
          if (e_valid && bus.o_valid) begin
            check("o_pc", bus.o_pc, sb[0].pc);
            check("o_instr", bus.o_instr, memf(sb[0].pc));
            if (bus.i_de_ready) begin
              void'(sb.pop_front());
              retired_cnt++;
            end
          end
        end
        last_stall = e_stall;
        exp_mreq   = e_mreq;
        exp_addr   = e_addr;
      end
    end
  end

  // One stimulus cycle: drive at the falling edge, then advance the reference
  // after the monitor has sampled, ahead of the rising edge.
  task automatic drive_cycle(input bit force_clr);
    bit req, flush, mrdy, rv, do_clr;
    @(negedge clk);
    req    = !last_stall && ($urandom_range(99) < p_req);
    flush  = ($urandom_range(99) < p_flush);
    mrdy   = ($urandom_range(99) < p_mrdy);
    do_clr = force_clr || ($urandom_range(999) < p_clr);
    rv     = (mq.size() > 0) && (mq[0].due <= cyc);
    clr              = do_clr;
    bus.i_instr_req  = req;
    bus.i_pc         = next_pc;
    bus.i_flush      = flush;
    bus.i_de_ready   = ($urandom_range(99) < p_de);
    bus.i_mem_ready  = mrdy;
    bus.i_mem_rvalid = rv;
    bus.i_mem_rdata  = rv ? mq[0].data : 32'hDEAD_BEEF;
    #3;
    if (do_clr) begin
      sb.delete();
      mq.delete();
      last_due = 0;
    end else begin
      int drop;
      drop = drop_model();
      if (rv) begin
        void'(mq.pop_front());
        if (drop == 0) begin
          bit hit = 0;
          foreach (sb[i]) begin
            if (!hit && sb[i].issued && !sb[i].done) begin
              sb[i].done = 1'b1;
              hit = 1;
            end
          end
        end
      end
      if (exp_mreq && mrdy) begin
        bit hit = 0;
        int due;
        foreach (sb[i]) begin
          if (!hit && !sb[i].issued) begin
            sb[i].issued = 1'b1;
            hit = 1;
          end
        end
        due = cyc + $urandom_range(lat_max, 1);
        if (due <= last_due) due = last_due + 1;
        mq.push_back('{data: memf(exp_addr), due: due});
        last_due = due;
      end
      if (flush) sb.delete();
      else if (req) begin
        sb.push_back('{pc: next_pc, issued: 1'b0, done: 1'b0});
        alloc_cnt++;
      end
    end
    if (flush) next_pc = {$urandom_range(32'hFFFF), 2'b00} + 32'h200;
    else if (req) next_pc = next_pc + 32'd4;
    cyc++;
    if (cyc >= 1) chk_en = 1'b1;
  endtask

  task automatic set_mode(input int rq, input int fl, input int de, input int mr,
                          input int lm, input int cl);
    p_req = rq; p_flush = fl; p_de = de; p_mrdy = mr; lat_max = lm; p_clr = cl;
  endtask

  initial begin
    clr = 1'b1;
    bus.i_instr_req = 0; bus.i_pc = '0; bus.i_flush = 0; bus.i_de_ready = 0;
    bus.i_mem_ready = 0; bus.i_mem_rvalid = 0; bus.i_mem_rdata = '0;
    set_mode(0, 0, 0, 0, 1, 0);
    repeat (3) drive_cycle(1'b1);
    repeat (2) drive_cycle(1'b0);

    // Streaming from PC 0 with single-cycle memory and free-running decode.
    next_pc = '0;
    alloc_cnt = 0;
    retired_cnt = 0;
    set_mode(100, 0, 100, 100, 1, 0);
    while (next_pc < 32'd64 && cyc < 200) drive_cycle(1'b0);
    set_mode(0, 0, 100, 100, 1, 0);
    repeat (10) drive_cycle(1'b0);
    check("stream_count", 32'(retired_cnt), 32'(alloc_cnt));

    // Decode back-pressure, then release.
    set_mode(100, 0, 0, 100, 1, 0);
    repeat (20) drive_cycle(1'b0);
    set_mode(100, 0, 100, 100, 1, 0);
    repeat (20) drive_cycle(1'b0);

    // Memory back-pressure with a request pending at 0x100.
    set_mode(0, 0, 100, 100, 1, 0);
    repeat (8) drive_cycle(1'b0);
    next_pc = 32'h100;
    set_mode(100, 0, 100, 0, 1, 0);
    repeat (8) drive_cycle(1'b0);
    set_mode(50, 0, 100, 100, 2, 0);
    repeat (20) drive_cycle(1'b0);

    // Long latency with flushes, including flush-cycle coincidences.
    set_mode(80, 6, 70, 70, 4, 0);
    repeat (1500) drive_cycle(1'b0);

    // Random mix with occasional mid-stream reset.
    set_mode(80, 4, 70, 70, 4, 10);
    repeat (1000) drive_cycle(1'b0);

    // Drain.
    set_mode(0, 0, 100, 100, 1, 0);
    repeat (30) drive_cycle(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
